// File: rtl/collision_detector_pkg.sv
// Shared constants and state encoding for the collision detector, game FSM and renderer.
// STAT_W_DEFAULT only exists when COLLISION_STATS_EN is defined.
package collision_detector_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam int unsigned THRESHOLD_DEFAULT = 4;
    localparam int unsigned CNT_W_DEFAULT     = 10;
`ifdef COLLISION_STATS_EN
    localparam int unsigned STAT_W_DEFAULT    = 16;
`endif

endpackage

// File: rtl/collision_detector_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// at_threshold compares the current registered value against THRESHOLD.
module sat_counter
    import collision_detector_pkg::*;
#(
    parameter int unsigned W         = CNT_W_DEFAULT,
    parameter int unsigned THRESHOLD = THRESHOLD_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         at_threshold
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + 1'b1;
        end
    end

    assign at_threshold = (32'(value) >= THRESHOLD);

endmodule

// File: rtl/collision_detector.sv
// Per-frame wall-overlap detector producing collided_new / collided_old for the game FSM.
// Define COLLISION_STATS_EN to add the lifetime stat_frames / stat_new_hits / stat_old_hits outputs.
module collision_detector
    import collision_detector_pkg::*;
#(
    parameter int unsigned THRESHOLD = THRESHOLD_DEFAULT,
`ifdef COLLISION_STATS_EN
    parameter int unsigned STAT_W    = STAT_W_DEFAULT,
`endif
    parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_start,
    input  logic frame_end,
    input  logic pixel_valid,
    input  logic player_new_px,
    input  logic player_old_px,
    input  logic wall_px,
    input  logic enable,
    input  logic game_reset,
    input  logic revert_player,
    output logic collided_new,
    output logic collided_old,
    output logic frame_busy
`ifdef COLLISION_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_frames,
    output logic [STAT_W-1:0] stat_new_hits,
    output logic [STAT_W-1:0] stat_old_hits
`endif
);

    state_t           state;
    logic             grace;
    logic             grace_armed;
    logic             start_accept;
    logic             frame_done;
    logic             count_ok;
    logic             inc_new;
    logic             inc_old;
    logic             cnt_clr;
    logic             hit_new;
    logic             hit_old;
    logic             at_thr_new;
    logic             at_thr_old;
    logic [CNT_W-1:0] cnt_new;
    logic [CNT_W-1:0] cnt_old;

    // Counters only ever run in SCAN after a clearing frame_start, so the flag can be
    // predicted from the current count plus this cycle's increment.
    always_comb begin
        start_accept = enable & frame_start & ~frame_end;
        frame_done   = enable & frame_end & (state == ST_SCAN);
        count_ok     = ~game_reset & enable & ~frame_start & ~frame_end
                     & pixel_valid & (state == ST_SCAN);
        inc_new      = count_ok & player_new_px & wall_px & ~grace;
        inc_old      = count_ok & player_old_px & wall_px;
        cnt_clr      = game_reset | start_accept;
        hit_new      = at_thr_new | (inc_new & (32'(cnt_new) == THRESHOLD - 1));
        hit_old      = at_thr_old | (inc_old & (32'(cnt_old) == THRESHOLD - 1));
    end

    sat_counter #(
        .W         (CNT_W),
        .THRESHOLD (THRESHOLD)
    ) u_cnt_new (
        .clk          (clk),
        .reset        (reset),
        .clr          (cnt_clr),
        .inc          (inc_new),
        .value        (cnt_new),
        .at_threshold (at_thr_new)
    );

    sat_counter #(
        .W         (CNT_W),
        .THRESHOLD (THRESHOLD)
    ) u_cnt_old (
        .clk          (clk),
        .reset        (reset),
        .clr          (cnt_clr),
        .inc          (inc_old),
        .value        (cnt_old),
        .at_threshold (at_thr_old)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            collided_new <= 1'b0;
            collided_old <= 1'b0;
            frame_busy   <= 1'b0;
        end else if (game_reset || !enable || frame_end) begin
            state        <= ST_IDLE;
            collided_new <= 1'b0;
            collided_old <= 1'b0;
            frame_busy   <= 1'b0;
        end else if (frame_start) begin
            state        <= ST_SCAN;
            collided_new <= 1'b0;
            collided_old <= 1'b0;
            frame_busy   <= 1'b1;
        end else if (state == ST_SCAN) begin
            collided_new <= hit_new;
            collided_old <= hit_old;
        end
    end

    // Grace lasts through the first frame that starts strictly after the revert pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grace       <= 1'b0;
            grace_armed <= 1'b0;
        end else if (game_reset) begin
            grace       <= 1'b0;
            grace_armed <= 1'b0;
        end else if (revert_player) begin
            grace       <= 1'b1;
            grace_armed <= 1'b0;
        end else if (grace) begin
            if (frame_done && grace_armed) begin
                grace       <= 1'b0;
                grace_armed <= 1'b0;
            end else if (start_accept) begin
                grace_armed <= 1'b1;
            end
        end
    end

`ifdef COLLISION_STATS_EN
    sat_counter #(
        .W         (STAT_W),
        .THRESHOLD (1)
    ) u_stat_frames (
        .clk          (clk),
        .reset        (reset),
        .clr          (game_reset),
        .inc          (frame_done),
        .value        (stat_frames),
        .at_threshold ()
    );

    sat_counter #(
        .W         (STAT_W),
        .THRESHOLD (1)
    ) u_stat_new_hits (
        .clk          (clk),
        .reset        (reset),
        .clr          (game_reset),
        .inc          (frame_done & collided_new),
        .value        (stat_new_hits),
        .at_threshold ()
    );

    sat_counter #(
        .W         (STAT_W),
        .THRESHOLD (1)
    ) u_stat_old_hits (
        .clk          (clk),
        .reset        (reset),
        .clr          (game_reset),
        .inc          (frame_done & collided_old),
        .value        (stat_old_hits),
        .at_threshold ()
    );
`endif

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: directed scenarios plus random frames,
// checked against per-frame overlap tallies kept by the bench.
module tb_collision_detector;

    localparam int THR     = 4;
    localparam int CW      = 10;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_start = 1'b0;
    logic frame_end = 1'b0;
    logic pixel_valid = 1'b0;
    logic player_new_px = 1'b0;
    logic player_old_px = 1'b0;
    logic wall_px = 1'b0;
    logic enable = 1'b1;
    logic game_reset = 1'b0;
    logic revert_player = 1'b0;
    logic collided_new;
    logic collided_old;
    logic frame_busy;
`ifdef COLLISION_STATS_EN
    logic [15:0] stat_frames;
    logic [15:0] stat_new_hits;
    logic [15:0] stat_old_hits;
`endif

    always #5 clk = ~clk;

    collision_detector #(
        .THRESHOLD (THR),
        .CNT_W     (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .pixel_valid   (pixel_valid),
        .player_new_px (player_new_px),
        .player_old_px (player_old_px),
        .wall_px       (wall_px),
        .enable        (enable),
        .game_reset    (game_reset),
        .revert_player (revert_player),
        .collided_new  (collided_new),
        .collided_old  (collided_old),
        .frame_busy    (frame_busy)
`ifdef COLLISION_STATS_EN
        ,
        .stat_frames   (stat_frames),
        .stat_new_hits (stat_new_hits),
        .stat_old_hits (stat_old_hits)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int e_new    = 0;   // overlaps the spec says are counted in the current frame
    int e_old    = 0;
    bit pn [2100];
    bit po [2100];
    bit pw [2100];

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input bit exp_busy, input bit live);
        check({tag, ".busy"}, 32'(frame_busy), 32'(exp_busy));
        check({tag, ".collided_new"}, 32'(collided_new), 32'(live && (e_new >= THR)));
        check({tag, ".collided_old"}, 32'(collided_old), 32'(live && (e_old >= THR)));
        check({tag, ".cnt_new"}, 32'(dut.u_cnt_new.value), 32'(sat(e_new)));
        check({tag, ".cnt_old"}, 32'(dut.u_cnt_old.value), 32'(sat(e_old)));
    endtask

    task automatic step(input bit fs, input bit fe, input bit pv, input bit nn,
                        input bit oo, input bit ww, input bit gr, input bit rv);
        frame_start   = fs;
        frame_end     = fe;
        pixel_valid   = pv;
        player_new_px = nn;
        player_old_px = oo;
        wall_px       = ww;
        game_reset    = gr;
        revert_player = rv;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pat(input int n);
        for (int i = 0; i < n; i++) begin
            pn[i] = 1'b0;
            po[i] = 1'b0;
            pw[i] = 1'b0;
        end
    endtask

    // graced: whole frame ignores new overlaps; rv_at: pixel index carrying a revert pulse
    task automatic run_frame(input string tag, input int n, input bit graced, input int rv_at);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        e_new = 0;
        e_old = 0;
        check_all({tag, ".start"}, 1'b1, 1'b1);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 1, pn[i], po[i], pw[i], 0, (i == rv_at));
            if (pn[i] && pw[i] && !(graced || (rv_at >= 0 && i > rv_at))) e_new++;
            if (po[i] && pw[i]) e_old++;
            check_all({tag, ".px"}, 1'b1, 1'b1);
        end
        step(0, 1, 1, 1, 1, 1, 0, 0);
        check_all({tag, ".end"}, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0);
        reset = 1'b0;
        step(0, 0, 1, 1, 1, 1, 0, 0);
        check_all("idle_px", 1'b0, 1'b0);

        // 4 consecutive new overlaps at pixels 20..23 of a 100-pixel frame
        clear_pat(100);
        for (int i = 20; i < 24; i++) begin
            pn[i] = 1'b1;
            pw[i] = 1'b1;
        end
        run_frame("t1", 100, 0, -1);

        // 3 new overlaps never reach THRESHOLD, 5 old overlaps do
        clear_pat(40);
        for (int i = 5; i < 8; i++) begin
            pn[i] = 1'b1;
            pw[i] = 1'b1;
        end
        for (int i = 10; i < 15; i++) begin
            po[i] = 1'b1;
            pw[i] = 1'b1;
        end
        run_frame("t2", 40, 0, -1);

        // revert in IDLE: next frame graced, the one after counts
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check_all("t3.rv", 1'b0, 1'b0);
        clear_pat(30);
        for (int i = 3; i < 13; i++) begin
            pn[i] = 1'b1;
            pw[i] = 1'b1;
        end
        run_frame("t3.grace", 30, 1, -1);
        run_frame("t3.after", 30, 0, -1);

        // revert mid-frame: rest of this frame and all of the next are graced
        clear_pat(20);
        for (int i = 0; i < 20; i++) begin
            pn[i] = 1'b1;
            pw[i] = 1'b1;
        end
        run_frame("t3b.mid", 20, 0, 2);
        run_frame("t3b.next", 20, 1, -1);
        run_frame("t3b.after", 20, 0, -1);

        // 2000 overlaps: counters saturate at 1023, flags stay high
        for (int i = 0; i < 2000; i++) begin
            pn[i] = 1'b1;
            po[i] = 1'b1;
            pw[i] = 1'b1;
        end
        run_frame("t4.sat", 2000, 0, -1);

        // frame_start with frame_end: no scan, counters keep previous frame's values
        step(1, 1, 1, 1, 1, 1, 0, 0);
        check_all("t6.se", 1'b0, 1'b0);
        repeat (3) begin
            step(0, 0, 1, 1, 1, 1, 0, 0);
            check_all("t6.noscan", 1'b0, 1'b0);
        end

        // async reset mid-SCAN after collided_old has risen
        step(1, 0, 0, 0, 0, 0, 0, 0);
        e_new = 0;
        e_old = 0;
        check_all("t5.start", 1'b1, 1'b1);
        repeat (4) begin
            step(0, 0, 1, 0, 1, 1, 0, 0);
            e_old++;
            check_all("t5.px", 1'b1, 1'b1);
        end
        #2;
        reset = 1'b1;
        #1;
        e_old = 0;
        check_all("t5.arst", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) begin
            step(0, 0, 1, 1, 1, 1, 0, 0);
            check_all("t5.post", 1'b0, 1'b0);
        end

        // game_reset during SCAN with flags high also cancels a pending grace
        step(1, 0, 0, 0, 0, 0, 0, 0);
        e_new = 0;
        e_old = 0;
        check_all("t7.start", 1'b1, 1'b1);
        repeat (4) begin
            step(0, 0, 1, 1, 1, 1, 0, 0);
            e_new++;
            e_old++;
            check_all("t7.px", 1'b1, 1'b1);
        end
        step(0, 0, 1, 1, 1, 1, 0, 1);
        e_new++;
        e_old++;
        check_all("t7.rv", 1'b1, 1'b1);
        step(0, 0, 1, 1, 1, 1, 0, 0);
        e_old++;
        check_all("t7.graced", 1'b1, 1'b1);
        step(1, 0, 1, 1, 1, 1, 1, 0);
        e_new = 0;
        e_old = 0;
        check_all("t7.grst", 1'b0, 1'b0);
        clear_pat(12);
        for (int i = 2; i < 8; i++) begin
            pn[i] = 1'b1;
            pw[i] = 1'b1;
        end
        run_frame("t7.after", 12, 0, -1);

        // enable low: counters frozen, flags low, back to IDLE, frame_start ignored
        step(1, 0, 0, 0, 0, 0, 0, 0);
        e_new = 0;
        e_old = 0;
        check_all("t8.start", 1'b1, 1'b1);
        repeat (5) begin
            step(0, 0, 1, 0, 1, 1, 0, 0);
            e_old++;
            check_all("t8.px", 1'b1, 1'b1);
        end
        enable = 1'b0;
        step(0, 0, 1, 1, 1, 1, 0, 0);
        check_all("t8.dis", 1'b0, 1'b0);
        step(1, 0, 1, 1, 1, 1, 0, 0);
        check_all("t8.dis_fs", 1'b0, 1'b0);
        enable = 1'b1;
        step(0, 0, 1, 1, 1, 1, 0, 0);
        check_all("t8.reen", 1'b0, 1'b0);

        // frame_start inside SCAN restarts the frame
        step(1, 0, 0, 0, 0, 0, 0, 0);
        e_new = 0;
        e_old = 0;
        check_all("t9.start", 1'b1, 1'b1);
        repeat (5) begin
            step(0, 0, 1, 1, 0, 1, 0, 0);
            e_new++;
            check_all("t9.px", 1'b1, 1'b1);
        end
        step(1, 0, 1, 1, 1, 1, 0, 0);
        e_new = 0;
        e_old = 0;
        check_all("t9.restart", 1'b1, 1'b1);
        repeat (4) begin
            step(0, 0, 1, 1, 0, 1, 0, 0);
            e_new++;
            check_all("t9.px2", 1'b1, 1'b1);
        end
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check_all("t9.end", 1'b0, 1'b0);

        // random frames separated by random idle gaps
        repeat (10) begin
            int n;
            n = int'($urandom_range(10, 60));
            for (int i = 0; i < n; i++) begin
                pw[i] = 1'($urandom_range(0, 1));
                pn[i] = ($urandom_range(0, 3) == 0);
                po[i] = ($urandom_range(0, 4) == 0);
            end
            run_frame("rnd", n, 0, -1);
            repeat (int'($urandom_range(0, 3))) begin
                step(0, 0, 1'($urandom_range(0, 1)), 1, 1, 1, 0, 0);
                check_all("rnd.gap", 1'b0, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/collision_detector.md
Name: collision_detector

Overview:
- Pixel-stream collision detector that produces the collided_new / collided_old flags consumed by the game-state FSM.
- Sits beside the renderer. Each active pixel it receives three layer masks: player at the new position, player at the old position, and wall.
- Counts overlaps per frame and asserts a flag once a count reaches THRESHOLD; the flag holds until frame end.
- Responds to the FSM's update / revert_player / game_reset pulses to re-arm and to apply a grace frame.

Parameters:
- THRESHOLD, 4: overlapping pixels per frame required to declare a collision (min 1).
- CNT_W, 10: width of the per-frame overlap counters; counters saturate.
- STAT_W, 16: width of the lifetime statistics counters (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- frame_start  in  1  one-cycle pulse at start of active frame
- frame_end  in  1  one-cycle pulse after last active pixel
- pixel_valid  in  1  current cycle carries an active pixel
- player_new_px  in  1  pixel lies inside player sprite at new position
- player_old_px  in  1  pixel lies inside player sprite at old position
- wall_px  in  1  pixel lies inside a wall
- enable  in  1  detection enabled (tie to ~game_over)
- game_reset  in  1  one-cycle game restart pulse from FSM
- revert_player  in  1  one-cycle pulse: player moved back to old position
- collided_new  out  1  new-position overlap count >= THRESHOLD this frame
- collided_old  out  1  old-position overlap count >= THRESHOLD this frame
- frame_busy  out  1  high while in SCAN

Behaviour:
- Reset values: all outputs 0, both counters 0, state IDLE, grace 0.

State machine:
- IDLE: on frame_start & enable, clear both counters and go to SCAN.
- SCAN: each cycle with pixel_valid & enable, cnt_new += (player_new_px & wall_px) unless grace is set; cnt_old += (player_old_px & wall_px). On frame_end go to IDLE.
- frame_busy = (state == SCAN), registered.

Counters and flags:
- Counters saturate at 2^CNT_W-1; no wrap.
- Flags are registered. collided_x rises in the cycle after the pixel that brings cnt_x to THRESHOLD; no combinational input-to-output path.
- Flags stay high until the cycle after frame_end, then both clear together.

Priority and boundary cases:
- frame_start and frame_end in the same cycle: frame_end wins. Go to / stay in IDLE with flags cleared; the frame is not scanned.
- frame_start while in SCAN (missing frame_end): clear counters and flags, restart SCAN.
- enable low: counters frozen, flags forced low next cycle, state returns to IDLE.
- revert_player: sets grace. While grace is set, cnt_new does not count (new == old after a revert). Grace clears at the frame_end of the next complete frame that starts after the pulse.
- game_reset: next cycle, clear counters, flags and grace; state goes to IDLE. It takes priority over all other inputs in that cycle.
- reset asserted mid-frame: immediate return to reset values. After release, wait for a fresh frame_start.
- A pixel on the frame_end cycle is not counted.

Optional Feature:
- Macro: COLLISION_STATS_EN.
- With it defined, add outputs stat_frames (STAT_W), stat_new_hits (STAT_W) and stat_old_hits (STAT_W).
  - stat_frames counts completed SCAN frames.
  - stat_new_hits / stat_old_hits count frames that ended with the respective flag high.
  - All three saturate and are cleared by reset and game_reset.
- Without it: ports and logic are absent; core behaviour is identical.

Decomposition:
- Shared package holds:
  - state encodings: ST_IDLE = 0, ST_SCAN = 1;
  - default THRESHOLD and CNT_W constants, shared with the game FSM and renderer.
- One natural sub-module: sat_counter (parameterised width; inc, clr, value, at_threshold compare). Instantiated twice, plus three times under COLLISION_STATS_EN.

Test Plan:
- Frame of 100 pixels, 4 consecutive new&wall pixels at 20..23, THRESHOLD=4 -> collided_new rises the cycle after pixel 23, collided_old stays 0, both low the cycle after frame_end.
- 3 new&wall pixels and 5 old&wall pixels in one frame -> collided_new never asserts; collided_old asserts after the 4th old overlap.
- revert_player pulse, then a frame with 10 new&wall and 0 old&wall overlaps -> no collided_new that frame. Following frame with the same pattern -> collided_new asserts.
- 2000 overlapping pixels with CNT_W=10 -> counter holds at 1023, flag stays high, no wrap.
- Assert reset mid-SCAN after collided_old has risen -> all outputs 0 immediately. Pixels before the next frame_start are ignored.
- frame_start and frame_end in the same cycle, then game_reset pulse during a later SCAN with flags high -> first: no scan, flags 0; second: flags and counters clear next cycle, state IDLE.
